// File: rtl/lcd_char_streamer_if.sv
// Character stream input and Avalon-MM master bus of the LCD character streamer.
// The streamer takes the master modport; the LCD controller and the character source take slave.
interface lcd_char_streamer_if;
    logic [7:0] char_data;
    logic       char_valid;
    logic       char_ready;
    logic       address;
    logic       chipselect;
    logic       write;
    logic [7:0] writedata;
    logic       waitrequest;

    modport master (
        input  char_data,
        input  char_valid,
        input  waitrequest,
        output char_ready,
        output address,
        output chipselect,
        output write,
        output writedata
    );

    modport slave (
        output char_data,
        output char_valid,
        output waitrequest,
        input  char_ready,
        input  address,
        input  chipselect,
        input  write,
        input  writedata
    );
endinterface

// File: rtl/lcd_char_streamer.sv
// Buffers an ASCII byte stream and drives a 2-row character LCD controller over Avalon-MM,
// tracking the cursor to insert line changes for wrap and newline.
module lcd_char_streamer #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned COLS       = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    lcd_char_streamer_if.master         bus,
    input  logic                        clear_req,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned ColW = $clog2(COLS + 1);
    localparam logic [7:0]      Newline = 8'h0A;
    localparam logic [7:0]      CmdClear = 8'h01;
    localparam logic [ColW-1:0] ColMax  = ColW'(COLS);
    localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

    typedef enum logic [2:0] {StIdle, StClear, StWrChar, StWrap, StNewline} state_e;

    state_e          state_q;
    logic            cs_q;
    logic            addr_q;
    logic [7:0]      wdata_q;
    logic [ColW-1:0] col_q;
    logic            row_q;
    logic            clear_pending_q;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            push;
    logic            pop;
    logic [7:0]      head;
    logic [7:0]      line_cmd;

    // Ready comes from the registered count only, so a pop never admits a same-cycle push.
    assign bus.char_ready = ~reset & (count_q < CntFull);
    assign push           = bus.char_valid & bus.char_ready;
    assign pop            = ((state_q == StWrChar) | (state_q == StNewline)) & ~bus.waitrequest;
    assign head           = mem_q[rd_ptr_q];
    assign line_cmd       = row_q ? 8'h80 : 8'hC0;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= bus.char_data;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            cs_q            <= 1'b0;
            addr_q          <= 1'b0;
            wdata_q         <= 8'h00;
            col_q           <= '0;
            row_q           <= 1'b0;
            clear_pending_q <= 1'b1;
        end else begin
            if (clear_req) begin
                clear_pending_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (clear_pending_q) begin
                        state_q <= StClear;
                        cs_q    <= 1'b1;
                        addr_q  <= 1'b0;
                        wdata_q <= CmdClear;
                    end else if (count_q != '0) begin
                        cs_q <= 1'b1;
                        if (head == Newline) begin
                            state_q <= StNewline;
                            addr_q  <= 1'b0;
                            wdata_q <= line_cmd;
                        end else if (col_q == ColMax) begin
                            state_q <= StWrap;
                            addr_q  <= 1'b0;
                            wdata_q <= line_cmd;
                        end else begin
                            state_q <= StWrChar;
                            addr_q  <= 1'b1;
                            wdata_q <= head;
                        end
                    end
                end
                StClear: begin
                    if (!bus.waitrequest) begin
                        state_q <= StIdle;
                        cs_q    <= 1'b0;
                        col_q   <= '0;
                        row_q   <= 1'b0;
                        // A request landing on the completion edge must survive.
                        if (!clear_req) begin
                            clear_pending_q <= 1'b0;
                        end
                    end
                end
                StWrChar: begin
                    if (!bus.waitrequest) begin
                        state_q <= StIdle;
                        cs_q    <= 1'b0;
                        if (col_q != ColMax) begin
                            col_q <= col_q + ColW'(1);
                        end
                    end
                end
                StWrap, StNewline: begin
                    if (!bus.waitrequest) begin
                        state_q <= StIdle;
                        cs_q    <= 1'b0;
                        row_q   <= ~row_q;
                        col_q   <= '0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cs_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.address    = addr_q;
    assign bus.chipselect = cs_q;
    assign bus.write      = cs_q;
    assign bus.writedata  = wdata_q;
    assign busy           = (state_q != StIdle) | (count_q != '0) | clear_pending_q;
    assign fifo_count     = count_q;
endmodule

// File: tb/tb_lcd_char_streamer.sv
// Directed bench for lcd_char_streamer: a cursor model feeds an expected-transaction queue
// that a negedge bus monitor drains as the LCD slave accepts writes.
module tb_lcd_char_streamer;
    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned COLS       = 16;
    localparam int          BigWait    = 1 << 30;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear_req;
    logic       busy;
    logic [4:0] fifo_count;

    lcd_char_streamer_if bus ();

    lcd_char_streamer #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .COLS      (COLS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .clear_req (clear_req),
        .busy      (busy),
        .fifo_count(fifo_count)
    );

    always #10 clk = ~clk;

    int         checks      = 0;
    int         failures    = 0;
    logic [8:0] exp_q[$];
    int         wait_cycles = 0;
    int         stall_cnt   = 0;
    bit         check_len   = 1'b0;
    int         m_col       = 0;
    bit         m_row       = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slave model: stall each transaction for wait_cycles cycles.
    always @(posedge clk) begin
        #1;
        if (bus.chipselect) begin
            if (stall_cnt < wait_cycles) begin
                bus.waitrequest = 1'b1;
                stall_cnt++;
            end else begin
                bus.waitrequest = 1'b0;
            end
        end else begin
            stall_cnt       = 0;
            bus.waitrequest = (wait_cycles > 0);
        end
    end

    logic       p_cs   = 1'b0;
    logic       p_wr   = 1'b0;
    logic       p_addr = 1'b0;
    logic       p_rst  = 1'b1;
    logic [7:0] p_data = 8'h00;
    int         len    = 0;
    logic [8:0] mon_e;

    always @(negedge clk) begin
        if (!reset && !p_rst) begin
            if (p_cs && p_wr) begin
                check("hold_cs", 32'(bus.chipselect), 32'd1);
                check("hold_addr", 32'(bus.address), 32'(p_addr));
                check("hold_data", 32'(bus.writedata), 32'(p_data));
            end
            if (p_cs && !p_wr) begin
                check("idle_gap", 32'(bus.chipselect), 32'd0);
            end
        end
        if (reset) begin
            len = 0;
        end else if (bus.chipselect) begin
            len++;
            check("write_eq_cs", 32'(bus.write), 32'd1);
            if (!bus.waitrequest) begin
                check("txn_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("txn", 32'({bus.address, bus.writedata}), 32'(mon_e));
                end
                if (check_len) begin
                    check("txn_len", 32'(len), 32'(wait_cycles + 1));
                end
                len = 0;
            end
        end else begin
            len = 0;
        end
        p_cs   = bus.chipselect;
        p_wr   = bus.waitrequest;
        p_addr = bus.address;
        p_data = bus.writedata;
        p_rst  = reset;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic model_line();
        exp_q.push_back({1'b0, m_row ? 8'h80 : 8'hC0});
        m_row = ~m_row;
        m_col = 0;
    endtask

    task automatic model_char(input logic [7:0] c);
        if (c == 8'h0A) begin
            model_line();
        end else begin
            if (m_col == COLS) model_line();
            exp_q.push_back({1'b1, c});
            m_col++;
        end
    endtask

    task automatic model_clear();
        exp_q.push_back(9'h001);
        m_col = 0;
        m_row = 1'b0;
    endtask

    task automatic send_char(input logic [7:0] c, input bit use_model = 1'b1);
        int n = 0;
        bus.char_data  = c;
        bus.char_valid = 1'b1;
        @(negedge clk);
        while (!bus.char_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("send_ready", 32'(bus.char_ready), 32'd1);
        tick();
        bus.char_valid = 1'b0;
        if (use_model) model_char(c);
    endtask

    task automatic pulse_clear();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drained"}, 32'(exp_q.size() == 0 && !busy), 32'd1);
        tick();
    endtask

    task automatic wait_cs(input string tag);
        int n = 0;
        @(negedge clk);
        while (!bus.chipselect && n < 50) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_cs_seen"}, 32'(bus.chipselect), 32'd1);
    endtask

    task automatic check_cursor(input string tag);
        check({tag, "_col"}, 32'(dut.col_q), 32'(m_col));
        check({tag, "_row"}, 32'(dut.row_q), 32'(m_row));
    endtask

    initial begin
        reset          = 1'b1;
        clear_req      = 1'b0;
        bus.char_valid = 1'b0;
        bus.char_data  = 8'h00;
        tick(3);
        @(negedge clk);
        check("rst_cs", 32'(bus.chipselect), 32'd0);
        check("rst_write", 32'(bus.write), 32'd0);
        check("rst_addr", 32'(bus.address), 32'd0);
        check("rst_wdata", 32'(bus.writedata), 32'h00);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_ready", 32'(bus.char_ready), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        tick();
        reset = 1'b0;
        model_clear();
        @(negedge clk);
        check("ready_after_reset", 32'(bus.char_ready), 32'd1);
        wait_drain("init");
        check("init_busy", 32'(busy), 32'd0);
        check_cursor("init");

        // "HI" with three wait states per write.
        wait_cycles = 3;
        check_len   = 1'b1;
        send_char(8'h48);
        send_char(8'h49);
        wait_drain("hi");
        check_len = 1'b0;
        check_cursor("hi");

        // 17 characters from home: wrap to row 1 before the last.
        wait_cycles = 0;
        pulse_clear();
        model_clear();
        for (int i = 0; i < 17; i++) send_char(8'h41);
        wait_drain("wrap");
        check_cursor("wrap");

        // Newlines from row 0 and row 1.
        pulse_clear();
        model_clear();
        send_char(8'h58);
        send_char(8'h0A);
        send_char(8'h59);
        send_char(8'h0A);
        wait_drain("newline");
        check_cursor("newline");

        // Fill the FIFO behind a stalled write, then release.
        wait_cycles = BigWait;
        for (int i = 0; i < 16; i++) send_char(8'h61 + 8'(i));
        @(negedge clk);
        check("full_count", 32'(fifo_count), 32'd16);
        check("full_ready", 32'(bus.char_ready), 32'd0);
        tick();
        bus.char_data  = 8'h71;
        bus.char_valid = 1'b1;
        tick(3);
        @(negedge clk);
        check("full_no_overflow", 32'(fifo_count), 32'd16);
        check("full_stalled_cs", 32'(bus.chipselect), 32'd1);
        tick();
        wait_cycles = 0;
        for (int i = 16; i < 20; i++) send_char(8'h61 + 8'(i));
        wait_drain("fill");
        check_cursor("fill");

        // Two clear pulses during one character write collapse to one clear.
        wait_cycles = 3;
        send_char(8'h5A);
        wait_cs("clr2");
        tick();
        pulse_clear();
        tick();
        pulse_clear();
        model_clear();
        wait_drain("clr2");
        check_cursor("clr2");

        // Reset while a write is stalled.
        wait_cycles = BigWait;
        send_char(8'h51, 1'b0);
        wait_cs("midrst");
        tick();
        send_char(8'h52, 1'b0);
        @(negedge clk);
        check("midrst_count", 32'(fifo_count), 32'd2);
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("midrst_cs_held", 32'(bus.chipselect), 32'd1);
        tick();
        reset       = 1'b0;
        wait_cycles = 0;
        @(negedge clk);
        check("midrst_cs_drop", 32'(bus.chipselect), 32'd0);
        check("midrst_write_drop", 32'(bus.write), 32'd0);
        check("midrst_flush", 32'(fifo_count), 32'd0);
        check("midrst_busy", 32'(busy), 32'd1);
        model_clear();
        wait_drain("midrst");
        check_cursor("midrst");
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lcd_char_streamer.md
Name: lcd_char_streamer

Overview:
- Avalon-MM master that sits directly upstream of the character-LCD controller slave.
- Accepts a valid/ready byte stream of ASCII characters into an internal FIFO.
- Tracks the cursor position on a 2-row display and issues instruction writes (clear, set DDRAM address) and data writes to the controller.
- Lets application logic print arbitrary text, with line wrap and newline handling, without sequencing the LCD itself.

Parameters:
FIFO_DEPTH, 16, character FIFO entries; power of two, 4 to 64
COLS, 16, visible columns per row; 1 to 40

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-high reset
char_data  in  8  ASCII byte to print; 0x0A = newline
char_valid  in  1  char_data valid
char_ready  out  1  FIFO can accept; transfer occurs when char_valid & char_ready
clear_req  in  1  single-cycle pulse: clear display and home cursor
address  out  1  0 = instruction register, 1 = data register
chipselect  out  1  Avalon chipselect
write  out  1  Avalon write strobe
writedata  out  8  instruction or character byte
waitrequest  in  1  slave stall; transaction holds while high
busy  out  1  high whenever FSM not in IDLE or FIFO non-empty
fifo_count  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset values:
  - address = 0, chipselect = 0, write = 0, writedata = 0x00.
  - busy = 1 (init clear pending).
  - char_ready = 0 during reset; char_ready = 1 from the first cycle after reset.
  - fifo_count = 0, col = 0, row = 0.
  - clear_pending = 1, so the first action after reset is a clear.
- Avalon transaction:
  - Drive chipselect = write = 1 with address/writedata stable.
  - Hold all four unchanged while waitrequest = 1.
  - Transaction completes on the first rising edge where waitrequest = 0.
  - chipselect/write deassert the following cycle.
  - At least one idle cycle between consecutive transactions.
  - read is never asserted.
- FIFO:
  - Synchronous, first-word fall-through to the FSM.
  - Push when char_valid & char_ready.
  - char_ready = (fifo_count < FIFO_DEPTH).
  - Simultaneous push and pop when full: the pop frees a slot, but char_ready is computed from the registered count, so no push occurs that cycle.
  - Pop occurs when the FSM commits a byte (see WR_CHAR / NEWLINE).
- clear_req:
  - Sets sticky clear_pending.
  - Multiple pulses before service collapse to one clear.
  - Checked only in IDLE and has priority over the FIFO.
- FSM states:
  - IDLE:
    - if clear_pending -> CLEAR;
    - else if FIFO non-empty: head == 0x0A -> NEWLINE; head != 0x0A and col == COLS -> WRAP; otherwise -> WR_CHAR.
  - CLEAR:
    - write address 0, data 0x01.
    - On completion: col = 0, row = 0, clear_pending = 0 (unless a new clear_req arrives that same cycle, in which case it stays set); -> IDLE.
  - WR_CHAR:
    - write address 1, data = FIFO head.
    - On completion: pop FIFO, col = col+1; -> IDLE.
  - WRAP:
    - write address 0, data = 0xC0 if row == 0, else 0x80.
    - On completion: row = ~row, col = 0; -> IDLE. The char is not popped; it prints next pass.
  - NEWLINE:
    - write address 0, data = 0xC0 if row == 0, else 0x80.
    - On completion: pop 0x0A, row = ~row, col = 0; -> IDLE.
- Width/arithmetic:
  - col is a clog2(COLS+1)-bit counter, saturating at COLS.
  - col only reaches COLS via WR_CHAR and returns to 0 only via WRAP, NEWLINE or CLEAR.
  - Row toggles 0 -> 1 -> 0; text wraps from row 1 back to row 0 (overwrite, no scroll).
- Non-printable bytes other than 0x0A are written as data unchanged.
- Reset asserted mid-transaction:
  - chipselect/write drop the next edge regardless of waitrequest.
  - FIFO is flushed and the init clear is re-issued.
- busy deasserts the cycle after the last transaction completes with an empty FIFO and no pending clear.

Test Plan:
- Reset, waitrequest tied 0 -> first transaction is address 0, data 0x01; then idle with busy = 0, col = 0.
- Stream "HI" after init, waitrequest held high 3 cycles per transaction -> data writes 0x48, 0x49 at address 1; each held stable 4 cycles; one idle cycle between writes; col = 2.
- Stream 17 × 'A' (COLS = 16) -> 16 data writes, then instruction 0xC0, then 17th 'A' as data; row = 1, col = 1.
- Stream "X", 0x0A, "Y", then 0x0A from row 1 -> writes: data 0x58, instr 0xC0, data 0x59, instr 0x80; newlines never appear as data writes.
- Push 20 bytes back-to-back with waitrequest = 1 -> char_ready drops when fifo_count = 16; no overflow; all 20 later printed in order.
- clear_req twice during a character write, then reset mid-transaction with waitrequest = 1 -> one 0x01 after that write; after reset, write drops next cycle, FIFO empty, 0x01 re-issued.
